// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
// Carries the IR fields and ALU zero flag in, and every mux select and write enable out.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_we;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] wd_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       zext_imm;
  logic       halt;

  modport master (
    input  opcode, funct, zero,
    output pc_we, pc_source, iord, mem_write, ir_write, reg_write,
           reg_dst, wd_src, alu_src_a, alu_src_b, alu_op, zext_imm, halt
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_we, pc_source, iord, mem_write, ir_write, reg_write,
           reg_dst, wd_src, alu_src_a, alu_src_b, alu_op, zext_imm, halt
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: one state per clock, Moore outputs except pc_we in BRANCH.
// ILLEGAL_TRAP_EN: when defined, illegal opcodes halt until reset; otherwise they are a one-cycle NOP.
module multicycle_control #(
  parameter int START_STATE_DELAY = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master bus
);

  localparam logic [1:0] DLY = 2'(START_STATE_DELAY);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_RTYPE_WB, S_EXEC_I, S_ITYPE_WB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ILLEGAL
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] dly_q, dly_d;
  logic       is_load_q, is_load_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      dly_q     <= 2'd0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      is_load_q <= is_load_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    dly_d         = dly_q;
    is_load_d     = is_load_q;
    bus.pc_we     = 1'b0;
    bus.pc_source = 2'd0;
    bus.iord      = 1'b0;
    bus.mem_write = 1'b0;
    bus.ir_write  = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_dst   = 2'd0;
    bus.wd_src    = 2'd0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 2'd0;
    bus.alu_op    = ALU_ADD;
    bus.zext_imm  = 1'b0;
    bus.halt      = 1'b0;

    unique case (state_q)
      S_RESET: begin
        if (dly_q == DLY) begin
          state_d = S_FETCH;
          dly_d   = 2'd0;
        end else begin
          dly_d   = dly_q + 2'd1;
        end
      end
      S_FETCH: begin
        bus.ir_write  = 1'b1;
        bus.alu_src_b = 2'd1;
        bus.pc_we     = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed speculatively here so BRANCH can just select it.
        bus.alu_src_b = 2'd3;
        state_d       = S_ILLEGAL;
        unique case (bus.opcode)
          OP_LW:   begin state_d = S_MEM_ADDR; is_load_d = 1'b1; end
          OP_SW:   begin state_d = S_MEM_ADDR; is_load_d = 1'b0; end
          OP_RTYPE: begin
            if (bus.funct == FN_ADD || bus.funct == FN_SUB || bus.funct == FN_SLT)
              state_d = S_EXEC_R;
            else if (bus.funct == FN_JR)
              state_d = S_JR;
          end
          OP_ADDI, OP_XORI: state_d = S_EXEC_I;
          OP_BNE:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          OP_JAL:  state_d = S_JAL;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd2;
        state_d       = is_load_q ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        bus.iord = 1'b1;
        state_d  = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.reg_write = 1'b1;
        bus.wd_src    = 2'd1;
        state_d       = S_FETCH;
      end
      S_MEM_WRITE: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        unique case (bus.funct)
          FN_SUB:  bus.alu_op = ALU_SUB;
          FN_SLT:  bus.alu_op = ALU_SLT;
          default: bus.alu_op = ALU_ADD;
        endcase
        state_d = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 2'd1;
        state_d       = S_FETCH;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd2;
        if (bus.opcode == OP_XORI) begin
          bus.alu_op   = ALU_XOR;
          bus.zext_imm = 1'b1;
        end
        state_d = S_ITYPE_WB;
      end
      S_ITYPE_WB: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_SUB;
        bus.pc_source = 2'd1;
        bus.pc_we     = ~bus.zero;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_source = 2'd3;
        bus.pc_we     = 1'b1;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        bus.pc_source = 2'd3;
        bus.pc_we     = 1'b1;
        bus.reg_write = 1'b1;
        bus.reg_dst   = 2'd2;
        bus.wd_src    = 2'd2;
        state_d       = S_FETCH;
      end
      S_JR: begin
        bus.pc_source = 2'd2;
        bus.pc_we     = 1'b1;
        state_d       = S_FETCH;
      end
      S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        bus.halt = 1'b1;
        state_d  = S_ILLEGAL;
`else
        state_d  = S_FETCH;
`endif
      end
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM of the multicycle CPU.
- Sits directly upstream of the PC-source mux, the register file, memory and ALU input muxes; its pc_source output is the mux select (0=ALU, 1=ALU_res, 2=A_out, 3=Concat_out).
- Decodes opcode/funct latched in the IR and sequences fetch/decode/execute/memory/writeback, one state per clock.

Parameters:
- START_STATE_DELAY, 0, extra idle cycles in RESET after rst_n deasserts before the first FETCH (0..3).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- opcode  input  6  IR[31:26].
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag (A-B) during BRANCH.
- pc_we  output  1  PC register write enable.
- pc_source  output  2  PC-source mux select.
- iord  output  1  memory address select: 0=PC, 1=ALU_res.
- mem_write  output  1  data memory write.
- ir_write  output  1  instruction register load.
- reg_write  output  1  register file write.
- reg_dst  output  2  write address: 0=rt, 1=rd, 2=$31.
- wd_src  output  2  write data: 0=ALU_res, 1=MDR, 2=PC.
- alu_src_a  output  1  0=PC, 1=A.
- alu_src_b  output  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- alu_op  output  3  0=ADD, 1=SUB, 2=XOR, 3=SLT.
- zext_imm  output  1  imm zero-extended on alu_src_b=2 (XORI).
- halt  output  1  illegal-instruction halt (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low; while sampled low at a rising edge, state<=RESET and the idle counter clears. Reset wins over any transition, including mid-instruction.
- Outputs: Moore-decoded from state, except pc_we in BRANCH.
  - In RESET every output is 0, including halt.
  - Outputs not listed for a state are 0.
- RESET: stay for START_STATE_DELAY cycles after rst_n high, then go to FETCH.
- FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0, pc_we=1. Next: DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALU_res). Dispatch:
  - 0x23 LW, 0x2B SW -> MEM_ADDR.
  - 0x00 with funct 0x20/0x22/0x2A -> EXEC_R.
  - 0x00 with funct 0x08 -> JR.
  - 0x08 ADDI, 0x0E XORI -> EXEC_I.
  - 0x05 BNE -> BRANCH.
  - 0x02 J -> JUMP.
  - 0x03 JAL -> JAL.
  - Anything else -> ILLEGAL.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD. Next: MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: iord=1. Next: MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, wd_src=1. Next: FETCH.
- MEM_WRITE: iord=1, mem_write=1. Next: FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op from funct (0x20 ADD, 0x22 SUB, 0x2A SLT). Next: RTYPE_WB.
- RTYPE_WB: reg_write=1, reg_dst=1, wd_src=0. Next: FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2; ADDI -> ADD/zext_imm=0, XORI -> XOR/zext_imm=1. Next: ITYPE_WB.
- ITYPE_WB: reg_write=1, reg_dst=0, wd_src=0. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_source=1, pc_we = ~zero (combinational). Next: FETCH.
- JUMP: pc_source=3, pc_we=1. Next: FETCH.
- JAL: pc_source=3, pc_we=1, reg_write=1, reg_dst=2, wd_src=2 (PC already +4). Next: FETCH.
- JR: pc_source=2, pc_we=1. Next: FETCH.
- ILLEGAL: see Optional Feature.
- Cycle counts, FETCH to next FETCH: LW 5; SW, R, I 4; BNE, J, JAL, JR 3.
- No two of pc_we/mem_write/ir_write are asserted in the same state except FETCH (pc_we+ir_write).
- opcode/funct are sampled only in DECODE and EXEC_R/EXEC_I; IR is stable there.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: ILLEGAL drives halt=1 and all write enables 0, and self-loops until reset.
- Undefined: ILLEGAL is a one-cycle NOP (all outputs 0) then FETCH; halt is tied to 0.

Test Plan:
- Reset: rst_n=0 for 2 cycles with START_STATE_DELAY=0 -> all outputs 0; first cycle after release: ir_write=1, pc_we=1, pc_source=0, alu_src_b=1.
- LW: opcode=0x23 -> 5-cycle sequence; MEM_READ iord=1; MEM_WB reg_write=1, wd_src=1, reg_dst=0; then FETCH.
- BNE: opcode=0x05, zero=0 -> BRANCH pc_we=1, pc_source=1. Repeat with zero=1 -> pc_we=0. Both return to FETCH after 3 cycles.
- JAL/JR: opcode=0x03 -> pc_source=3, pc_we=1, reg_write=1, reg_dst=2, wd_src=2. opcode=0x00/funct=0x08 -> pc_source=2, pc_we=1.
- Illegal: opcode=0x3F -> with ILLEGAL_TRAP_EN, halt=1 held for 10+ cycles, mem_write/reg_write/pc_we=0. Without it, FETCH after 1 NOP cycle.
- Reset mid-op: rst_n=0 in MEM_WRITE -> next edge all outputs 0, mem_write never re-asserted; clean FETCH after release.
